// File: rtl/param_shift_engine_if.sv
// rtl/param_shift_engine_if.sv - control/data bundle between the shift engine and its controlling FSM
interface param_shift_engine_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic [WIDTH-1:0] load_val;
  logic             load_en;
  logic [1:0]       mode;
  logic             ser_in;
  logic             start;
  logic [CNT_W-1:0] shift_cnt;
  logic             step_en;
  logic [WIDTH-1:0] op;
  logic             ser_out;
  logic             busy;
  logic             done;

  modport master (
    output load_val, load_en, mode, ser_in, start, shift_cnt, step_en,
    input  op, ser_out, busy, done
  );

  modport slave (
    input  load_val, load_en, mode, ser_in, start, shift_cnt, step_en,
    output op, ser_out, busy, done
  );
endinterface

// File: rtl/param_shift_engine.sv
// rtl/param_shift_engine.sv - WIDTH-bit load/rotate/shift register with counted bursts and single steps
// Optional: define PSE_ARITH_SHIFT_EN to make mode 11 an arithmetic (sign-filling) right shift.
module param_shift_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic                 clk,
  input logic                 rst,
  param_shift_engine_if.slave pse_if
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic             ser_out_q, ser_out_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;

  logic [1:0]       shift_mode;
  logic             fill;
  logic [WIDTH-1:0] shifted;
  logic             shifted_out;

  // A burst uses the mode latched at start; free steps follow the live mode.
  always_comb begin
    shift_mode = (state_q == RUN) ? mode_q : pse_if.mode;
`ifdef PSE_ARITH_SHIFT_EN
    fill = op_q[WIDTH-1];
`else
    fill = pse_if.ser_in;
`endif
    shifted     = op_q;
    shifted_out = ser_out_q;
    case (shift_mode)
      2'b00: begin
        shifted     = {op_q[WIDTH-2:0], op_q[WIDTH-1]};
        shifted_out = op_q[WIDTH-1];
      end
      2'b01: begin
        shifted     = {op_q[0], op_q[WIDTH-1:1]};
        shifted_out = op_q[0];
      end
      2'b10: begin
        shifted     = {op_q[WIDTH-2:0], pse_if.ser_in};
        shifted_out = op_q[WIDTH-1];
      end
      default: begin
        shifted     = {fill, op_q[WIDTH-1:1]};
        shifted_out = op_q[0];
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ser_out_d = ser_out_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    if (pse_if.load_en) begin
      op_d    = pse_if.load_val;
      state_d = IDLE;
    end else if (state_q == RUN) begin
      op_d      = shifted;
      ser_out_d = shifted_out;
      cnt_d     = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (pse_if.start) begin
      // A zero-length burst completes immediately without entering RUN.
      if (pse_if.shift_cnt == '0) begin
        done_d = 1'b1;
      end else begin
        state_d = RUN;
        cnt_d   = pse_if.shift_cnt;
        mode_d  = pse_if.mode;
      end
    end else if (pse_if.step_en) begin
      op_d      = shifted;
      ser_out_d = shifted_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      ser_out_q <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      mode_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ser_out_q <= ser_out_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
    end
  end

  assign pse_if.op      = op_q;
  assign pse_if.ser_out = ser_out_q;
  assign pse_if.busy    = (state_q == RUN);
  assign pse_if.done    = done_q;
endmodule

// File: tb/tb_param_shift_engine.sv
// tb/tb_param_shift_engine.sv - scoreboard bench for param_shift_engine against an arithmetic reference model
module tb_param_shift_engine;
  localparam int W    = 8;
  localparam int CW   = 4;
  localparam int MASK = (1 << W) - 1;

  logic clk;
  logic rst;

  param_shift_engine_if #(.WIDTH(W), .CNT_W(CW)) pse_if ();

  param_shift_engine #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .pse_if (pse_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] op;
    logic         ser;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int   m_op, m_ser, m_busy, m_done, m_rem, m_mode;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_op = 0; m_ser = 0; m_busy = 0; m_done = 0; m_rem = 0; m_mode = 0;
  endtask

  task automatic model_shift(input int md, input int sin);
    int v, f;
    v = m_op;
    case (md)
      0: begin m_ser = (v >> (W-1)) & 1; m_op = ((v << 1) | (v >> (W-1))) & MASK; end
      1: begin m_ser = v & 1;            m_op = (v >> 1) | ((v & 1) << (W-1)); end
      2: begin m_ser = (v >> (W-1)) & 1; m_op = ((v << 1) | sin) & MASK; end
      default: begin
`ifdef PSE_ARITH_SHIFT_EN
        f = (v >> (W-1)) & 1;
`else
        f = sin;
`endif
        m_ser = v & 1;
        m_op  = (v >> 1) | (f << (W-1));
      end
    endcase
  endtask

  task automatic model_edge();
    int ser_in_v;
    ser_in_v = int'(pse_if.ser_in);
    if (rst) begin
      model_reset();
      return;
    end
    m_done = 0;
    if (pse_if.load_en) begin
      m_op   = int'(pse_if.load_val);
      m_busy = 0;
    end else if (m_busy != 0) begin
      model_shift(m_mode, ser_in_v);
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 0;
        m_done = 1;
      end
    end else if (pse_if.start) begin
      if (pse_if.shift_cnt == 0) m_done = 1;
      else begin
        m_busy = 1;
        m_rem  = int'(pse_if.shift_cnt);
        m_mode = int'(pse_if.mode);
      end
    end else if (pse_if.step_en) begin
      model_shift(int'(pse_if.mode), ser_in_v);
    end
  endtask

  task automatic tick();
    exp_t e;
    model_edge();
    e.op   = m_op[W-1:0];
    e.ser  = m_ser[0];
    e.busy = m_busy[0];
    e.done = m_done[0];
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pse_if.load_en = 1'b0;
    pse_if.start   = 1'b0;
    pse_if.step_en = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    idle_inputs();
    pse_if.load_val = v;
    pse_if.load_en  = 1'b1;
    tick();
    pse_if.load_en  = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] md, input logic [CW-1:0] n, input logic sin);
    idle_inputs();
    pse_if.mode      = md;
    pse_if.shift_cnt = n;
    pse_if.ser_in    = sin;
    pse_if.start     = 1'b1;
    tick();
    pse_if.start     = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("op",      int'(pse_if.op),      int'(e.op));
      check("ser_out", int'(pse_if.ser_out), int'(e.ser));
      check("busy",    int'(pse_if.busy),    int'(e.busy));
      check("done",    int'(pse_if.done),    int'(e.done));
    end
  end

  initial begin
    rst = 1'b1;
    pse_if.load_val = '0; pse_if.mode = 2'b00; pse_if.ser_in = 1'b0;
    pse_if.shift_cnt = '0;
    idle_inputs();
    model_reset();
    @(negedge clk); #1;
    tick();
    rst = 1'b0;
    tick();

    do_load(8'h01);
    do_start(2'b00, 4'd3, 1'b0);
    repeat (3) tick();
    check("plan_rotl_op", int'(pse_if.op), 8'h08);
    check("plan_rotl_done", int'(pse_if.done), 1);
    tick();

    do_load(8'h81);
    do_start(2'b10, 4'd4, 1'b0);
    repeat (4) tick();
    check("plan_shl_op", int'(pse_if.op), 8'h10);

    do_load(8'h80);
    do_start(2'b11, 4'd2, 1'b1);
    repeat (2) tick();
    check("plan_shr_fill1", int'(pse_if.op), 8'hE0);
    do_load(8'h80);
    do_start(2'b11, 4'd2, 1'b0);
    repeat (2) tick();
`ifdef PSE_ARITH_SHIFT_EN
    check("plan_shr_fill0", int'(pse_if.op), 8'hE0);
`else
    check("plan_shr_fill0", int'(pse_if.op), 8'h20);
`endif

    do_load(8'h01);
    do_start(2'b00, 4'd8, 1'b0);
    repeat (2) tick();
    do_load(8'h55);
    check("abort_op", int'(pse_if.op), 8'h55);
    check("abort_busy", int'(pse_if.busy), 0);
    do_start(2'b00, 4'd0, 1'b0);
    check("zero_cnt_done", int'(pse_if.done), 1);
    check("zero_cnt_op", int'(pse_if.op), 8'h55);

    do_load(8'h81);
    pse_if.mode = 2'b01; pse_if.step_en = 1'b1;
    tick();
    pse_if.step_en = 1'b0;
    check("step_op", int'(pse_if.op), 8'hC0);
    check("step_no_done", int'(pse_if.done), 0);
    do_start(2'b01, 4'd4, 1'b0);
    pse_if.mode = 2'b00; pse_if.start = 1'b1; pse_if.step_en = 1'b1;
    tick();
    idle_inputs();
    repeat (3) tick();
    check("busy_ignore_op", int'(pse_if.op), 8'h0C);
    check("busy_ignore_done", int'(pse_if.done), 1);

    do_load(8'h01);
    do_start(2'b00, 4'd6, 1'b0);
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    check("async_rst_op", int'(pse_if.op), 0);
    check("async_rst_busy", int'(pse_if.busy), 0);
    check("async_rst_ser", int'(pse_if.ser_out), 0);
    check("async_rst_done", int'(pse_if.done), 0);
    model_reset();
    @(negedge clk); #1;
    tick();
    rst = 1'b0;
    do_start(2'b00, 4'd2, 1'b0);
    check("post_rst_busy", int'(pse_if.busy), 1);
    repeat (2) tick();

    for (int i = 0; i < 600; i++) begin
      pse_if.load_en   = ($urandom_range(0, 24) == 0);
      pse_if.load_val  = W'($urandom);
      pse_if.start     = ($urandom_range(0, 3) == 0);
      pse_if.shift_cnt = CW'($urandom);
      pse_if.mode      = 2'($urandom);
      pse_if.ser_in    = 1'($urandom);
      pse_if.step_en   = 1'($urandom);
      tick();
    end
    idle_inputs();
    repeat (2) tick();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
